// File: rtl/ibex_hpm_pkg.sv
// Shared constants and types for the HPM controller and its address decoder.
// IBEX_HPM_OVF_IRQ_EN enables the overflow status register and interrupt.
package ibex_hpm_pkg;

  localparam int unsigned EvSelW = 5;

  localparam logic [4:0] AddrInhibit   = 5'h00;
  localparam logic [4:0] AddrOvfStatus = 5'h01;
  localparam logic [1:0] AddrGrpSys    = 2'd0;
  localparam logic [1:0] AddrGrpSel    = 2'd1;
  localparam logic [1:0] AddrGrpLo     = 2'd2;
  localparam logic [1:0] AddrGrpHi     = 2'd3;

`ifdef IBEX_HPM_OVF_IRQ_EN
  localparam bit OvfIrqEn = 1'b1;
`else
  localparam bit OvfIrqEn = 1'b0;
`endif

  typedef logic [1:0] hpm_state_t;
  localparam hpm_state_t StIdle   = 2'd0;
  localparam hpm_state_t StAccess = 2'd1;
  localparam hpm_state_t StResp   = 2'd2;

  typedef enum logic [2:0] {
    RegNone,
    RegInhibit,
    RegOvf,
    RegSel,
    RegLo,
    RegHi
  } hpm_region_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } hpm_access_t;

endpackage

// File: rtl/ibex_hpm_csr_decode.sv
// Maps a 5-bit HPM CSR address to a register region, counter index and error flag.
// Purely combinational; indices at or above NumCounters decode as errors.
module ibex_hpm_csr_decode
  import ibex_hpm_pkg::*;
#(
  parameter int unsigned NumCounters = 4
) (
  input  logic [4:0]  addr,
  output hpm_region_e region,
  output logic [2:0]  index,
  output logic        err
);

  always_comb begin
    region = RegNone;
    index  = addr[2:0];
    case (addr[4:3])
      AddrGrpSys: begin
        if (addr == AddrInhibit) begin
          region = RegInhibit;
        end else if (OvfIrqEn && addr == AddrOvfStatus) begin
          region = RegOvf;
        end
      end
      AddrGrpSel: region = RegSel;
      AddrGrpLo:  region = RegLo;
      AddrGrpHi:  region = RegHi;
      default:    region = RegNone;
    endcase
    if ((region == RegSel || region == RegLo || region == RegHi) &&
        ({1'b0, addr[2:0]} >= 4'(NumCounters))) begin
      region = RegNone;
    end
    err = (region == RegNone);
  end

endmodule

// File: rtl/ibex_hpm_ctrl.sv
// HPM counter-bank controller: config, increment gating, CSR sequencing, torn-free 64-bit reads.
// IBEX_HPM_OVF_IRQ_EN adds sticky overflow status at 0x01 and ovf_irq_o.
module ibex_hpm_ctrl
  import ibex_hpm_pkg::*;
#(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned CounterWidth = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   event_i,
  input  logic                   csr_req_i,
  input  logic                   csr_we_i,
  input  logic [4:0]             csr_addr_i,
  input  logic [31:0]            csr_wdata_i,
  output logic                   csr_gnt_o,
  output logic                   csr_rvalid_o,
  output logic [31:0]            csr_rdata_o,
  output logic                   csr_err_o,
  output logic [NumCounters-1:0] counter_inc_o,
  output logic [NumCounters-1:0] counter_we_o,
  output logic [NumCounters-1:0] counterh_we_o,
  output logic [31:0]            counter_wdata_o,
  input  logic [63:0]            counter_val_i [NumCounters],
  output logic                   ovf_irq_o
);

  localparam logic [63:0] ValMask =
      (CounterWidth >= 64) ? {64{1'b1}} : ((64'd1 << CounterWidth) - 64'd1);

  hpm_state_t       state_q;
  hpm_access_t      acc_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [NumCounters-1:0] inhibit_q;
  logic [EvSelW-1:0] sel_q [NumCounters];
  logic [31:0]      shadow_q;
  logic             shadow_vld_q;
  logic [2:0]       shadow_idx_q;

  hpm_region_e region;
  logic [2:0]  idx;
  logic        dec_err;

  ibex_hpm_csr_decode #(
    .NumCounters(NumCounters)
  ) u_decode (
    .addr  (acc_q.addr),
    .region(region),
    .index (idx),
    .err   (dec_err)
  );

  logic        in_wr;
  logic        cnt_wr_lo;
  logic        cnt_wr_hi;
  logic [63:0] val_sel;
  logic [31:0] ev_pad;
  logic [31:0] rd_d;
  logic [NumCounters-1:0] inc_raw;

  assign in_wr     = (state_q == StAccess) && acc_q.we;
  assign cnt_wr_lo = in_wr && (region == RegLo);
  assign cnt_wr_hi = in_wr && (region == RegHi);
  assign ev_pad    = 32'(event_i);

  always_comb begin
    val_sel       = '0;
    counter_we_o  = '0;
    counterh_we_o = '0;
    inc_raw       = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      if (idx == 3'(k)) val_sel = counter_val_i[k] & ValMask;
      counter_we_o[k]  = cnt_wr_lo && (idx == 3'(k));
      counterh_we_o[k] = cnt_wr_hi && (idx == 3'(k));
      inc_raw[k] = !inhibit_q[k] && (sel_q[k] != '0) &&
                   ({1'b0, sel_q[k]} < 6'(NumEvents)) && ev_pad[sel_q[k]];
    end
  end

  // A load into a counter always beats its increment in the same cycle.
  assign counter_inc_o   = inc_raw & ~(counter_we_o | counterh_we_o);
  assign counter_wdata_o = (cnt_wr_lo || cnt_wr_hi) ? acc_q.wdata : '0;

`ifdef IBEX_HPM_OVF_IRQ_EN
  logic [NumCounters-1:0] ovf_q;
  logic [NumCounters-1:0] ovf_det;
  logic [NumCounters-1:0] ovf_clr;
  logic [NumCounters-1:0] ovf_d;
  logic                   irq_q;

  always_comb begin
    ovf_det = '0;
    for (int k = 0; k < int'(NumCounters); k++) begin
      ovf_det[k] = counter_inc_o[k] && ((counter_val_i[k] & ValMask) == ValMask);
    end
  end

  assign ovf_clr = (in_wr && region == RegOvf) ? acc_q.wdata[NumCounters-1:0] : '0;
  assign ovf_d   = (ovf_q & ~ovf_clr) | ovf_det;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_d;
    end
  end

  assign ovf_irq_o = irq_q;
`else
  assign ovf_irq_o = 1'b0;
`endif

  always_comb begin
    rd_d = '0;
    case (region)
      RegInhibit: rd_d = 32'(inhibit_q);
      RegSel: begin
        for (int k = 0; k < int'(NumCounters); k++) begin
          if (idx == 3'(k)) rd_d = 32'(sel_q[k]);
        end
      end
      RegLo: rd_d = val_sel[31:0];
      // The high half pairs with the snapshot taken by the preceding low-half read.
      RegHi: rd_d = (shadow_vld_q && shadow_idx_q == idx) ? shadow_q : val_sel[63:32];
`ifdef IBEX_HPM_OVF_IRQ_EN
      RegOvf: rd_d = 32'(ovf_q);
`endif
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (csr_req_i) begin
            acc_q   <= '{we: csr_we_i, addr: csr_addr_i, wdata: csr_wdata_i};
            state_q <= StAccess;
          end
        end
        StAccess: begin
          rdata_q <= acc_q.we ? '0 : rd_d;
          err_q   <= dec_err;
          state_q <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q    <= '1;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      shadow_idx_q <= '0;
      for (int k = 0; k < int'(NumCounters); k++) sel_q[k] <= '0;
    end else if (state_q == StAccess) begin
      if (acc_q.we) begin
        if (region == RegInhibit) inhibit_q <= acc_q.wdata[NumCounters-1:0];
        for (int k = 0; k < int'(NumCounters); k++) begin
          if (region == RegSel && idx == 3'(k)) sel_q[k] <= acc_q.wdata[EvSelW-1:0];
        end
        if (region == RegLo || region == RegHi) shadow_vld_q <= 1'b0;
      end else if (region == RegLo) begin
        shadow_q     <= val_sel[63:32];
        shadow_vld_q <= 1'b1;
        shadow_idx_q <= idx;
      end else if (region == RegHi && shadow_vld_q && shadow_idx_q == idx) begin
        shadow_vld_q <= 1'b0;
      end
    end
  end

  assign csr_gnt_o    = (state_q == StIdle) && csr_req_i;
  assign csr_rvalid_o = (state_q == StResp);
  assign csr_rdata_o  = csr_rvalid_o ? rdata_q : '0;
  assign csr_err_o    = csr_rvalid_o && err_q;

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
// Bench for ibex_hpm_ctrl: behavioural counter bank, register-map model, per-cycle strobe checks.
// Define IBEX_HPM_OVF_IRQ_EN to also cover the overflow status and interrupt.
module tb_ibex_hpm_ctrl;

  localparam int NC = 4;
  localparam int NE = 16;
  localparam int CW = 40;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NE-1:0] event_i = '0;
  logic          csr_req_i = 1'b0;
  logic          csr_we_i = 1'b0;
  logic [4:0]    csr_addr_i = '0;
  logic [31:0]   csr_wdata_i = '0;
  logic          csr_gnt_o, csr_rvalid_o, csr_err_o, ovf_irq_o;
  logic [31:0]   csr_rdata_o, counter_wdata_o;
  logic [NC-1:0] counter_inc_o, counter_we_o, counterh_we_o;
  logic [63:0]   cnt [NC] = '{default: 64'd0};

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [NC-1:0] inh_m = '1;
  int            sel_m [NC] = '{default: 0};
  logic          shadow_vld_m = 1'b0;
  int            shadow_idx_m = 0;
  logic [31:0]   shadow_m = '0;
  logic [NC-1:0] status_m = '0;
  logic          irq_m = 1'b0;
  logic [NC-1:0] load_m = '0, clr_m = '0, exp_we = '0, exp_weh = '0;
  logic [31:0]   exp_wdata = '0, exp_rdata = '0;
  logic          exp_gnt = 1'b0, exp_rvalid = 1'b0, exp_err = 1'b0;
  logic          chk_en = 1'b0, ev_auto = 1'b0;
  logic [NE-1:0] ev_dir = '0;
  int            inc0_cnt = 0, we2_cnt = 0;

  always #5 clk = ~clk;

  ibex_hpm_ctrl #(.NumCounters(NC), .NumEvents(NE), .CounterWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .event_i(event_i),
    .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o),
    .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o), .counter_inc_o(counter_inc_o),
    .counter_we_o(counter_we_o), .counterh_we_o(counterh_we_o),
    .counter_wdata_o(counter_wdata_o), .counter_val_i(cnt), .ovf_irq_o(ovf_irq_o)
  );

  // behavioural counter bank
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (counter_we_o[k]) cnt[k][31:0] <= counter_wdata_o;
      else if (counterh_we_o[k]) cnt[k][63:32] <= counter_wdata_o;
      else if (counter_inc_o[k]) cnt[k] <= cnt[k] + 64'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] r;
    forever begin
      @(posedge clk); #1;
      r = $urandom;
      event_i = ev_auto ? r[NE-1:0] : ev_dir;
    end
  end

  always @(negedge clk) begin
    logic [NC-1:0] ei;
    logic [NC-1:0] det;
    if (chk_en) begin
      ei = '0;
      det = '0;
      for (int k = 0; k < NC; k++) begin
        ei[k] = !inh_m[k] && sel_m[k] != 0 && sel_m[k] < NE && event_i[sel_m[k]] && !load_m[k];
        det[k] = ei[k] && ((cnt[k] & MASK) == MASK);
      end
      chk("inc", counter_inc_o, ei);
      chk("we", counter_we_o, exp_we);
      chk("weh", counterh_we_o, exp_weh);
      chk("wdata", counter_wdata_o, exp_wdata);
      chk("gnt", csr_gnt_o, exp_gnt);
      chk("rvalid", csr_rvalid_o, exp_rvalid);
      if (exp_rvalid) begin
        chk("rdata", csr_rdata_o, exp_rdata);
        chk("err", csr_err_o, exp_err);
      end
`ifdef IBEX_HPM_OVF_IRQ_EN
      chk("irq", ovf_irq_o, irq_m);
      status_m = (status_m & ~clr_m) | det;
      irq_m = |status_m;
`else
      chk("irq_tied", ovf_irq_o, 1'b0);
`endif
      if (counter_inc_o[0]) inc0_cnt++;
      if (counter_we_o[2]) we2_cnt++;
    end
  end

  task automatic csr(input logic we, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er_o);
    int grp, k;
    logic [31:0] er, hi_c;
    logic ee;
    grp = int'(a) / 8;
    k = int'(a) % 8;
    @(posedge clk); #1;
    csr_req_i = 1'b1; csr_we_i = we; csr_addr_i = a; csr_wdata_i = d;
    exp_gnt = 1'b1;
    @(posedge clk); #1;
    csr_req_i = 1'b0; csr_we_i = 1'($urandom); csr_addr_i = 5'($urandom); csr_wdata_i = $urandom;
    exp_gnt = 1'b0;
    er = '0; ee = 1'b0; hi_c = '0;
    if (a == 5'h00) er = 32'(inh_m);
`ifdef IBEX_HPM_OVF_IRQ_EN
    else if (a == 5'h01) er = 32'(status_m);
`endif
    else if (grp == 1 && k < NC) er = 32'(sel_m[k]);
    else if (grp == 2 && k < NC) begin
      er = 32'(cnt[k] & MASK);
      hi_c = 32'((cnt[k] & MASK) >> 32);
    end
    else if (grp == 3 && k < NC)
      er = (shadow_vld_m && shadow_idx_m == k) ? shadow_m : 32'((cnt[k] & MASK) >> 32);
    else ee = 1'b1;
    if (we) begin
      if (grp == 2 && k < NC) begin exp_we[k] = 1'b1; load_m[k] = 1'b1; exp_wdata = d; end
      if (grp == 3 && k < NC) begin exp_weh[k] = 1'b1; load_m[k] = 1'b1; exp_wdata = d; end
`ifdef IBEX_HPM_OVF_IRQ_EN
      if (a == 5'h01) clr_m = d[NC-1:0];
`endif
    end
    @(posedge clk); #1;
    exp_we = '0; exp_weh = '0; exp_wdata = '0; load_m = '0; clr_m = '0;
    if (we) begin
      if (a == 5'h00) inh_m = d[NC-1:0];
      if (grp == 1 && k < NC) sel_m[k] = int'(d[4:0]);
      if ((grp == 2 || grp == 3) && k < NC) shadow_vld_m = 1'b0;
    end else if (!ee) begin
      if (grp == 2) begin shadow_m = hi_c; shadow_vld_m = 1'b1; shadow_idx_m = k; end
      else if (grp == 3 && shadow_vld_m && shadow_idx_m == k) shadow_vld_m = 1'b0;
    end
    exp_rvalid = 1'b1; exp_rdata = we ? 32'd0 : er; exp_err = ee;
    #3;
    rd = csr_rdata_o; er_o = csr_err_o;
    @(posedge clk); #1;
    exp_rvalid = 1'b0;
  endtask

  task automatic model_reset();
    inh_m = '1;
    for (int k = 0; k < NC; k++) sel_m[k] = 0;
    shadow_vld_m = 1'b0; status_m = '0; irq_m = 1'b0;
    load_m = '0; clr_m = '0; exp_we = '0; exp_weh = '0; exp_wdata = '0;
    exp_gnt = 1'b0; exp_rvalid = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d;
    logic e;
    logic [4:0] a;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt", csr_gnt_o, 0);
    chk("rst_rvalid", csr_rvalid_o, 0);
    chk("rst_err", csr_err_o, 0);
    chk("rst_irq", ovf_irq_o, 0);
    chk("rst_strobes", {counter_inc_o, counter_we_o, counterh_we_o}, 0);
    chk("rst_wdata", counter_wdata_o, 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    csr(1'b0, 5'h00, 0, rd, e); chk("inhibit_reset", rd, 32'hF);
    csr(1'b0, 5'h08, 0, rd, e); chk("sel0_reset", rd, 0);
    ev_dir = '1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("inc_all_inhibited", counter_inc_o, 0);
    ev_dir = '0;

    csr(1'b1, 5'h08, 3, rd, e);
    csr(1'b1, 5'h00, 0, rd, e);
    repeat (2) @(posedge clk);
    inc0_cnt = 0;
    #2 ev_dir = NE'(8);
    repeat (5) @(posedge clk);
    #2 ev_dir = '0;
    repeat (3) @(posedge clk);
    chk("inc0_cycles", inc0_cnt, 5);

    we2_cnt = 0;
    csr(1'b1, 5'h12, 32'hDEADBEEF, rd, e);
    chk("we2_pulses", we2_cnt, 1);
    chk("cnt2_loaded", cnt[2][31:0], 32'hDEADBEEF);

    csr(1'b1, 5'h19, 32'h1, rd, e);
    csr(1'b1, 5'h11, 32'hFFFFFFFF, rd, e);
    csr(1'b0, 5'h11, 0, rd, e); chk("snap_lo", rd, 32'hFFFFFFFF);
    csr(1'b1, 5'h09, 5, rd, e);
    #2 ev_dir = NE'(32);
    @(posedge clk);
    #2 ev_dir = '0;
    repeat (2) @(posedge clk);
    csr(1'b0, 5'h19, 0, rd, e); chk("snap_hi_shadow", rd, 32'h1);
    csr(1'b0, 5'h19, 0, rd, e); chk("snap_hi_live", rd, 32'h2);
    csr(1'b1, 5'h09, 0, rd, e);

    csr(1'b0, 5'h14, 0, rd, e); chk("unmapped_err", e, 1); chk("unmapped_rdata", rd, 0);
    csr(1'b1, 5'h1F, 32'h1234, rd, e); chk("bad_write_err", e, 1);

    csr(1'b1, 5'h18, 32'hFF, rd, e);
    csr(1'b1, 5'h10, 32'hFFFFFFFF, rd, e);
    #2 ev_dir = NE'(8);
    @(posedge clk);
    #2 ev_dir = '0;
    @(posedge clk);
    @(negedge clk);
`ifdef IBEX_HPM_OVF_IRQ_EN
    chk("ovf_irq_set", ovf_irq_o, 1);
    csr(1'b1, 5'h01, 32'h1, rd, e);
    @(negedge clk); chk("ovf_irq_clr", ovf_irq_o, 0);
`else
    chk("ovf_irq_off", ovf_irq_o, 0);
    csr(1'b0, 5'h01, 0, rd, e); chk("ovf_addr_unmapped", e, 1);
`endif

    ev_auto = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      if (a[4:3] == 2'd1) d = $urandom_range(0, 20);
      csr(1'(i % 3 != 0), a, d, rd, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 5'h10; exp_gnt = 1'b1;
    @(posedge clk); #1;
    csr_req_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    csr(1'b0, 5'h00, 0, rd, e); chk("inhibit_after_rst", rd, 32'hF);
    csr(1'b0, 5'h0A, 0, rd, e); chk("sel2_after_rst", rd, 0);
    ev_auto = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
